safe: RTL and testbench

SAFE -- requirements
Module: safe

---
 rtl/safe.sv | 132 +++++++++++++
 tb/tb_safe.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/safe.sv
// Four-nibble combination lock: unlocks only on the exact CODE sequence.
// Optional wrong-attempt lockout is compiled in with `define SAFE_LOCKOUT_EN.
module safe #(
  parameter logic [15:0] CODE      = 16'hC0DE,
  parameter logic [3:0]  MAX_FAILS = 4'd3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] din,
  input  logic       din_valid,
  output logic       unlocked
);

`ifdef SAFE_LOCKOUT_EN
  typedef enum logic [1:0] {ENTRY = 2'd0, OPEN = 2'd1, LOCKOUT = 2'd2} state_t;
`else
  typedef enum logic [1:0] {ENTRY = 2'd0, OPEN = 2'd1} state_t;
`endif

  state_t      state_r;
  state_t      next_state_s;
  logic [1:0]  idx_r;
  logic [1:0]  next_idx_s;
  logic        mismatch_r;
  logic        next_mismatch_s;
  logic        digit_bad_s;
  logic        unlocked_s;
  logic        unlocked_r;
`ifdef SAFE_LOCKOUT_EN
  logic [3:0]  fail_cnt_r;
  logic [3:0]  next_fail_cnt_s;
`endif

  function automatic logic [3:0] code_digit(input logic [1:0] k);
    logic [3:0] d;
    case (k)
      2'd0:    d = CODE[15:12];
      2'd1:    d = CODE[11:8];
      2'd2:    d = CODE[7:4];
      2'd3:    d = CODE[3:0];
      default: d = 4'd0;
    endcase
    return d;
  endfunction

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ENTRY;
      idx_r      <= 2'd0;
      mismatch_r <= 1'b0;
      unlocked_r <= 1'b0;
`ifdef SAFE_LOCKOUT_EN
      fail_cnt_r <= 4'd0;
`endif
    end else begin
      state_r    <= next_state_s;
      idx_r      <= next_idx_s;
      mismatch_r <= next_mismatch_s;
      unlocked_r <= unlocked_s;
`ifdef SAFE_LOCKOUT_EN
      fail_cnt_r <= next_fail_cnt_s;
`endif
    end
  end

  // Next-state and digit-tracking logic; din is only looked at under din_valid
  always_comb begin
    next_state_s    = state_r;
    next_idx_s      = idx_r;
    next_mismatch_s = mismatch_r;
    digit_bad_s     = 1'b0;
`ifdef SAFE_LOCKOUT_EN
    next_fail_cnt_s = fail_cnt_r;
`endif
    case (state_r)
      ENTRY: begin
        if (din_valid) begin
          digit_bad_s = (din != code_digit(idx_r));
          if (idx_r == 2'd3) begin
            next_idx_s      = 2'd0;
            next_mismatch_s = 1'b0;
            if (!mismatch_r && !digit_bad_s) begin
              next_state_s = OPEN;
            end else begin
`ifdef SAFE_LOCKOUT_EN
              next_fail_cnt_s = fail_cnt_r + 4'd1;
              if ((fail_cnt_r + 4'd1) == MAX_FAILS) begin
                next_state_s = LOCKOUT;
              end else begin
                next_state_s = ENTRY;
              end
`else
              next_state_s = ENTRY;
`endif
            end
          end else begin
            next_idx_s      = idx_r + 2'd1;
            next_mismatch_s = mismatch_r | digit_bad_s;
          end
        end else begin
          next_idx_s = idx_r;
        end
      end
      OPEN: begin
        next_state_s = OPEN;
      end
`ifdef SAFE_LOCKOUT_EN
      LOCKOUT: begin
        next_state_s = LOCKOUT;
      end
`endif
      default: begin
        next_state_s    = ENTRY;
        next_idx_s      = 2'd0;
        next_mismatch_s = 1'b0;
      end
    endcase
  end

  // Output decode, registered so unlocked rises on the edge that enters OPEN
  always_comb begin
    unlocked_s = 1'b0;
    case (next_state_s)
      OPEN:    unlocked_s = 1'b1;
      default: unlocked_s = 1'b0;
    endcase
  end

  assign unlocked = unlocked_r;

endmodule

// File: tb/tb_safe.sv
// Directed self-checking bench for the safe combination lock.
module tb_safe;
  logic       clk;
  logic       reset;
  logic [3:0] din;
  logic       din_valid;
  logic       unlocked;

  int errors = 0;
  int checks = 0;

  safe dut (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .din_valid (din_valid),
    .unlocked  (unlocked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic expected);
    checks++;
    assert (unlocked === expected) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, unlocked, expected);
    end
  endtask

  // Present one digit for exactly one sampling edge, then return #1 after it.
  task automatic put(input logic [3:0] d);
    @(negedge clk);
    din       = d;
    din_valid = 1'b1;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    din       = 4'bxxxx;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Two-cycle reset with a valid digit presented that must be ignored.
  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    din       = 4'hC;
    din_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset     = 1'b0;
    din_valid = 1'b0;
    din       = 4'bxxxx;
  endtask

  task automatic put_code(input logic [15:0] c);
    logic [15:0] v;
    v = c;
    put(v[15:12]);
    put(v[11:8]);
    put(v[7:4]);
    put(v[3:0]);
  endtask

  initial begin
    reset     = 1'b1;
    din       = 4'h0;
    din_valid = 1'b0;

    do_reset();
    chk("reset_state", 1'b0);

    // Correct code on consecutive cycles
    put(4'hC); put(4'h0); put(4'hD);
    chk("three_digits", 1'b0);
    put(4'hE);
    chk("correct_code", 1'b1);
    idle(20);
    chk("open_after_idle", 1'b1);
    put_code(16'h1234);
    chk("open_ignores_input", 1'b1);

    do_reset();
    chk("reset_from_open", 1'b0);
    put_code(16'h1234);
    chk("wrong_1234", 1'b0);
    put_code(16'hC0DE);
    chk("retry_after_1234", 1'b1);

    do_reset();
    put_code(16'hC0DF);
    chk("wrong_last_digit", 1'b0);
    put_code(16'hC0DE);
    chk("retry_after_c0df", 1'b1);

    // Idle gaps with X on din must not disturb a partial entry
    do_reset();
    put(4'hC); idle(3);
    put(4'h0); idle(3);
    put(4'hD); idle(3);
    chk("gapped_partial", 1'b0);
    put(4'hE);
    chk("gapped_code", 1'b1);

    do_reset();
    put(4'hC); put(4'h0);
    do_reset();
    put(4'hD); put(4'hE);
    chk("reset_discards_prefix", 1'b0);
    idle(5);
    chk("reset_discards_idle", 1'b0);

    // Reset-time digit ignored: 0,D,E then one more digit is a bad attempt
    do_reset();
    put(4'h0); put(4'hD); put(4'hE);
    chk("reset_digit_ignored", 1'b0);
    put(4'hE);
    chk("reset_digit_ignored_full", 1'b0);

    // Five-digit entry with a leading extra digit does not unlock
    do_reset();
    put(4'hC); put(4'hC); put(4'h0); put(4'hD); put(4'hE);
    chk("extra_digit", 1'b0);

    // Three wrong codes, then the right one
    do_reset();
    put_code(16'h1234);
    chk("fail_1", 1'b0);
    put_code(16'h1234);
    chk("fail_2", 1'b0);
    put_code(16'h1234);
    chk("fail_3", 1'b0);
    put_code(16'hC0DE);
`ifdef SAFE_LOCKOUT_EN
    chk("lockout_blocks_code", 1'b0);
    do_reset();
    put_code(16'hC0DE);
    chk("unlock_after_lockout_reset", 1'b1);
`else
    chk("fourth_attempt_unlocks", 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
